// File: rtl/steer_ctrl_pkg.sv
// rtl/steer_ctrl_pkg.sv - shared car-control constants: direction codes, states, pattern map
package steer_ctrl_pkg;

    localparam logic [2:0] DIR_STRAIGHT    = 3'b000;
    localparam logic [2:0] DIR_LEFT_SMALL  = 3'b001;
    localparam logic [2:0] DIR_LEFT_BIG    = 3'b011;
    localparam logic [2:0] DIR_RIGHT_SMALL = 3'b101;
    localparam logic [2:0] DIR_RIGHT_BIG   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SEARCH = 2'd3
    } state_t;

    typedef struct packed {
        logic       none;
        logic [2:0] code;
    } steer_map_t;

    // Outer sensors dominate inner ones; symmetric patterns steer straight.
    function automatic steer_map_t map_pattern(input logic [4:0] p);
        steer_map_t r;
        r.none = (p == 5'b00000);
        if (p[4] && !p[0])      r.code = DIR_LEFT_BIG;
        else if (p[0] && !p[4]) r.code = DIR_RIGHT_BIG;
        else if (p[3] && !p[1]) r.code = DIR_LEFT_SMALL;
        else if (p[1] && !p[3]) r.code = DIR_RIGHT_SMALL;
        else                    r.code = DIR_STRAIGHT;
        return r;
    endfunction

    // Full lock toward the side the line was last seen on.
    function automatic logic [2:0] search_code(input logic [2:0] last);
        if (last[2])      return DIR_RIGHT_BIG;
        else if (last[0]) return DIR_LEFT_BIG;
        else              return DIR_STRAIGHT;
    endfunction

endpackage

// File: rtl/steer_ctrl_tick_div.sv
// rtl/steer_ctrl_tick_div.sv - sample tick divider, one-cycle tick every DIV cycles
module tick_div #(
    parameter int DIV = 1000
) (
    input  logic clkus,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clkus or posedge rst) begin
        if (rst)              cnt <= '0;
        else if (clr)         cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/steer_ctrl.sv
// rtl/steer_ctrl.sv - line-following steering controller: sync, debounce, track/hold/search FSM
module steer_ctrl
    import steer_ctrl_pkg::*;
#(
    parameter int SAMPLE_US  = 1000,
    parameter int DEBOUNCE_N = 3,
    parameter int HOLD_MS    = 200,
    parameter int LOST_MS    = 1000
) (
    input  logic       clkus,
    input  logic       rst,
    input  logic       enable,
    input  logic [4:0] sensors,
    output logic [2:0] direction,
    output logic       lost,
    output logic       timeout
);

    localparam int RW     = $clog2(DEBOUNCE_N + 1);
    localparam int MS_MAX = (LOST_MS > HOLD_MS) ? LOST_MS : HOLD_MS;
    localparam int MW     = $clog2(MS_MAX + 1);

    localparam logic [RW-1:0] RUN_MAX  = RW'(DEBOUNCE_N);
    localparam logic [MW-1:0] MS_LIM   = MW'(MS_MAX);
    localparam logic [MW-1:0] HOLD_LIM = MW'(HOLD_MS);
    localparam logic [MW-1:0] LOST_LIM = MW'(LOST_MS);

    state_t     state, state_n;
    logic [2:0] dir_n;
    logic       lost_n, timeout_n;

    logic [4:0]    sync_a, sync_b, prev_smp;
    logic [RW-1:0] run_cnt, run_next;
    logic [MW-1:0] ms_cnt, ms_n, ms_inc;
    logic          tick, accept;
    steer_map_t    mapped;

    tick_div #(.DIV(SAMPLE_US)) u_tick (
        .clkus (clkus),
        .rst   (rst),
        .clr   (state == ST_IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clkus or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= sensors;
            sync_b <= sync_a;
        end
    end

    // Accept on the tick the run count hits DEBOUNCE_N and on every equal tick after.
    always_comb begin
        run_next = RW'(1);
        if (sync_b == prev_smp)
            run_next = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
        accept = tick && (run_next == RUN_MAX);
    end

    always_ff @(posedge clkus or posedge rst) begin
        if (rst) begin
            prev_smp <= '0;
            run_cnt  <= '0;
        end else if (tick) begin
            prev_smp <= sync_b;
            run_cnt  <= run_next;
        end
    end

    assign mapped = map_pattern(sync_b);
    assign ms_inc = (ms_cnt == MS_LIM) ? ms_cnt : ms_cnt + 1'b1;

    always_ff @(posedge clkus or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            direction <= DIR_STRAIGHT;
            lost      <= 1'b0;
            timeout   <= 1'b0;
            ms_cnt    <= '0;
        end else begin
            state     <= state_n;
            direction <= dir_n;
            lost      <= lost_n;
            timeout   <= timeout_n;
            ms_cnt    <= ms_n;
        end
    end

    always_comb begin
        state_n   = state;
        dir_n     = direction;
        lost_n    = lost;
        timeout_n = timeout;
        ms_n      = ms_cnt;
        if (!enable) begin
            state_n   = ST_IDLE;
            dir_n     = DIR_STRAIGHT;
            lost_n    = 1'b0;
            timeout_n = 1'b0;
            ms_n      = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n   = ST_TRACK;
                    dir_n     = DIR_STRAIGHT;
                    lost_n    = 1'b0;
                    timeout_n = 1'b0;
                    ms_n      = '0;
                end
                ST_TRACK: begin
                    lost_n = 1'b0;
                    if (accept) begin
                        if (mapped.none) begin
                            state_n = ST_HOLD;
                            ms_n    = '0;
                        end else begin
                            dir_n = mapped.code;
                        end
                    end
                end
                ST_HOLD: begin
                    // A fresh line beats expiry on the same tick.
                    if (accept && !mapped.none) begin
                        state_n = ST_TRACK;
                        dir_n   = mapped.code;
                    end else if (tick) begin
                        ms_n = ms_inc;
                        if (ms_inc == HOLD_LIM) begin
                            state_n = ST_SEARCH;
                            dir_n   = search_code(direction);
                            lost_n  = 1'b1;
                            ms_n    = '0;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (accept && !mapped.none) begin
                        state_n = ST_TRACK;
                        dir_n   = mapped.code;
                        lost_n  = 1'b0;
                    end else if (tick) begin
                        ms_n = ms_inc;
                        if (ms_inc == LOST_LIM)
                            timeout_n = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    dir_n   = DIR_STRAIGHT;
                    lost_n  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_steer_ctrl.sv
// tb/tb_steer_ctrl.sv - directed self-checking bench for steer_ctrl with shortened timebase
module tb_steer_ctrl;

    localparam int S   = 8;
    localparam int N   = 3;
    localparam int HMS = 5;
    localparam int LMS = 10;

    logic       clkus   = 1'b0;
    logic       rst     = 1'b1;
    logic       enable  = 1'b0;
    logic [4:0] sensors = 5'b00000;
    logic [2:0] direction;
    logic       lost;
    logic       timeout;

    int n_vec = 0;
    int n_bad = 0;
    int n;
    int dev;

    logic [4:0] tab_p [7] = '{5'b00010, 5'b01010, 5'b01000, 5'b11111, 5'b00001, 5'b10001, 5'b10110};
    logic [2:0] tab_d [7] = '{3'b101,   3'b000,   3'b001,   3'b000,   3'b111,   3'b000,   3'b011};

    always #5 clkus = ~clkus;

    steer_ctrl #(
        .SAMPLE_US  (S),
        .DEBOUNCE_N (N),
        .HOLD_MS    (HMS),
        .LOST_MS    (LMS)
    ) dut (
        .clkus     (clkus),
        .rst       (rst),
        .enable    (enable),
        .sensors   (sensors),
        .direction (direction),
        .lost      (lost),
        .timeout   (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_dir(input logic [2:0] exp, input int bound, output int cyc);
        cyc = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clkus);
            if (direction === exp) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clkus);
        chk("rst_dir", direction, 3'b000);
        chk("rst_lost", lost, 1'b0);
        chk("rst_timeout", timeout, 1'b0);

        sensors = 5'b00100;
        rst     = 1'b0;
        enable  = 1'b1;
        dev = 0;
        for (int i = 0; i < 5 * S; i++) begin
            @(negedge clkus);
            if (direction !== 3'b000 || lost !== 1'b0) dev++;
        end
        chk("straight_steady", dev, 0);

        sensors = 5'b00010;
        repeat (2 * S) @(negedge clkus);
        sensors = 5'b00100;
        dev = 0;
        for (int i = 0; i < 4 * S; i++) begin
            @(negedge clkus);
            if (direction !== 3'b000) dev++;
        end
        chk("glitch_ignored", dev, 0);

        sensors = 5'b11000;
        wait_dir(3'b011, 3 * S + 3, n);
        chk("left_big_dir", direction, 3'b011);
        chk("left_big_latency_in_window", (n >= 2 * S + 2 && n <= 3 * S + 3), 1);

        sensors = 5'b01100;
        wait_dir(3'b001, 3 * S + 3, n);
        chk("left_small_dir", direction, 3'b001);

        sensors = 5'b00000;
        n = 0;
        dev = 0;
        for (int i = 1; i <= 8 * S + 4; i++) begin
            @(negedge clkus);
            if (lost === 1'b1) begin
                n = i;
                break;
            end
            if (direction !== 3'b001) dev++;
        end
        chk("hold_dir_kept", dev, 0);
        chk("hold_length_in_window", (n >= 7 * S + 2 && n <= 8 * S + 3), 1);
        chk("search_dir", direction, 3'b011);
        chk("search_lost", lost, 1'b1);
        chk("search_timeout_clear", timeout, 1'b0);

        n = 0;
        for (int i = 1; i <= LMS * S + 3; i++) begin
            @(negedge clkus);
            if (timeout === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("timeout_length_in_window", (n >= LMS * S - 1 && n <= LMS * S + 1), 1);
        chk("timeout_set", timeout, 1'b1);
        chk("timeout_still_lost", lost, 1'b1);

        sensors = 5'b00110;
        wait_dir(3'b101, 3 * S + 3, n);
        chk("recover_dir", direction, 3'b101);
        chk("recover_lost", lost, 1'b0);
        chk("recover_timeout", timeout, 1'b1);
        repeat (2 * S) @(negedge clkus);
        chk("timeout_sticky", timeout, 1'b1);

        enable = 1'b0;
        @(negedge clkus);
        chk("disable_timeout", timeout, 1'b0);
        chk("disable_dir", direction, 3'b000);

        enable  = 1'b1;
        sensors = 5'b10000;
        wait_dir(3'b011, 3 * S + 5, n);
        chk("relock_dir", direction, 3'b011);
        sensors = 5'b00000;
        repeat (4 * S) @(negedge clkus);
        chk("mid_hold_lost", lost, 1'b0);
        chk("mid_hold_dir", direction, 3'b011);

        sensors = 5'b10000;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_dir", direction, 3'b000);
        chk("async_rst_lost", lost, 1'b0);
        chk("async_rst_timeout", timeout, 1'b0);
        @(negedge clkus);
        rst = 1'b0;
        wait_dir(3'b011, 3 * S + 6, n);
        chk("post_rst_dir", direction, 3'b011);
        chk("post_rst_full_debounce", (n >= 2 * S + 2), 1);

        for (int k = 0; k < 7; k++) begin
            sensors = tab_p[k];
            repeat (3 * S + 4) @(negedge clkus);
            chk($sformatf("map_%b", tab_p[k]), direction, tab_d[k]);
        end

        sensors = 5'b00011;
        wait_dir(3'b111, 3 * S + 3, n);
        chk("right_big_dir", direction, 3'b111);
        enable = 1'b0;
        @(negedge clkus);
        chk("drop_en_dir", direction, 3'b000);
        chk("drop_en_lost", lost, 1'b0);
        chk("drop_en_timeout", timeout, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
